// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin arbiter that shares one SR latch among NREQ
// requesters. A granted requester gets a fixed-width S or R pulse, an optional
// readback check on q_in, then a single-cycle req_ready acknowledge.
// Optional feature macro: SR_CTRL_TIMEOUT_EN (adds VERIFY state, timeout,
// err/err_src). Without it, DRIVE goes straight to DONE and err/err_src are 0.
module sr_latch_ctrl #(
    parameter int NREQ      = 4,
    parameter int PULSE_CYC = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_op,
    output logic [NREQ-1:0]         req_ready,
    output logic                    s_out,
    output logic                    r_out,
    input  logic                    q_in,
    output logic                    busy,
    output logic                    err,
    output logic [$clog2(NREQ)-1:0] err_src
);

    localparam int IW   = $clog2(NREQ);
    // One counter serves both the pulse phase and the verify phase, so it is
    // sized for whichever of the two can run longer.
    localparam int CMAX = (PULSE_CYC > TIMEOUT) ? PULSE_CYC : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, VERIFY, DONE} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] g;
    logic          exp_q;
    logic [CW-1:0] cnt;

    logic          gnt_found;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   scan;

    // Round-robin pick: first valid index starting at ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(NREQ))
                scan = scan - (IW+1)'(NREQ);
            if (!gnt_found && req_valid[scan[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IW-1:0];
            end
        end
    end

`ifndef SR_CTRL_TIMEOUT_EN
    assign err     = 1'b0;
    assign err_src = '0;
`endif

    // Controller FSM; every output is a register so S/R glitches never reach the latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            g         <= '0;
            exp_q     <= 1'b0;
            cnt       <= '0;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            busy      <= 1'b0;
            req_ready <= '0;
`ifdef SR_CTRL_TIMEOUT_EN
            err       <= 1'b0;
            err_src   <= '0;
`endif
        end else begin
            req_ready <= '0;
`ifdef SR_CTRL_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        g     <= gnt_idx;
                        exp_q <= req_op[gnt_idx];
                        busy  <= 1'b1;
                        cnt   <= '0;
                        if (q_in == req_op[gnt_idx]) begin
                            // Latch already holds the requested value: acknowledge without a pulse.
                            state     <= DONE;
                            req_ready <= NREQ'(1) << gnt_idx;
                        end else begin
                            state <= DRIVE;
                            s_out <= req_op[gnt_idx];
                            r_out <= !req_op[gnt_idx];
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == CW'(PULSE_CYC - 1)) begin
                        s_out <= 1'b0;
                        r_out <= 1'b0;
                        cnt   <= '0;
`ifdef SR_CTRL_TIMEOUT_EN
                        state <= VERIFY;
`else
                        state     <= DONE;
                        req_ready <= NREQ'(1) << g;
`endif
                    end else begin
                        // S and R are complementary here and both low elsewhere.
                        s_out <= exp_q;
                        r_out <= !exp_q;
                        cnt   <= cnt + 1'b1;
                    end
                end
`ifdef SR_CTRL_TIMEOUT_EN
                VERIFY: begin
                    if (q_in == exp_q) begin
                        state     <= DONE;
                        req_ready <= NREQ'(1) << g;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        req_ready <= NREQ'(1) << g;
                        err       <= 1'b1;
                        err_src   <= g;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    s_out <= 1'b0;
                    r_out <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: directed scenarios then random operations, each
// checked against an operation-level model (grant order, pulse count, latency).
module tb_sr_latch_ctrl;

    localparam int NREQ = 4;
    localparam int P    = 2;
    localparam int TO   = 8;
`ifdef SR_CTRL_TIMEOUT_EN
    localparam int LAT    = P + 2;
    localparam bit HAS_TO = 1'b1;
`else
    localparam int LAT    = P + 1;
    localparam bit HAS_TO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_op = '0;
    logic [NREQ-1:0] req_ready;
    logic            s_out, r_out, busy, err;
    logic [1:0]      err_src;

    // Behavioural SR latch: follows S/R one clock later; can be forced or stuck.
    logic lat_q = 1'b0;
    logic lat_force_en = 1'b0;
    logic lat_force_val = 1'b0;
    logic lat_stuck = 1'b0;

    int errors = 0;
    int checks = 0;

    // Model state
    int   m_ptr = 0;
    logic m_q = 1'b0;

    sr_latch_ctrl #(.NREQ(NREQ), .PULSE_CYC(P), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .s_out(s_out), .r_out(r_out), .q_in(lat_q),
        .busy(busy), .err(err), .err_src(err_src)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lat_force_en) lat_q <= lat_force_val;
        else if (!lat_stuck) begin
            if (s_out) lat_q <= 1'b1;
            else if (r_out) lat_q <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // Put the latch into a known value with no request pending (call at negedge).
    task automatic force_q(input logic val);
        req_valid     = '0;
        lat_force_en  = 1'b1;
        lat_force_val = val;
        @(negedge clk);
        lat_force_en  = 1'b0;
        m_q           = val;
    endtask

    // One operation: drive request at a negedge, watch until acknowledge, compare to model.
    task automatic run_op(input string tag, input logic [NREQ-1:0] v,
                          input logic [NREQ-1:0] op, input int drop_at, input bit stuck);
        int g, lat, s_cnt, r_cnt, both, rdy_k, err_k, exp_s, exp_r, rdy_ones;
        logic [NREQ-1:0] rdy_val;
        bit skip;
        g    = rr_pick(m_ptr, v);
        skip = (m_q == op[g]);
        if (skip) lat = 1;
        else if (stuck && HAS_TO) lat = P + 1 + TO;
        else lat = LAT;
        exp_s = (!skip && op[g]) ? P : 0;
        exp_r = (!skip && !op[g]) ? P : 0;
        s_cnt = 0; r_cnt = 0; both = 0; rdy_k = 0; err_k = 0; rdy_val = '0; rdy_ones = 0;

        req_valid = v;
        req_op    = op;
        for (int k = 1; k <= 60 && rdy_k == 0; k++) begin
            @(negedge clk);
            if (k == drop_at) req_valid[g] = 1'b0;
            if (k == 1) chk({tag, ".busy"}, 32'(busy), 32'd1);
            if (s_out) s_cnt++;
            if (r_out) r_cnt++;
            if (s_out && r_out) both++;
            if (err) err_k = k;
            if (req_ready != '0) begin
                rdy_k   = k;
                rdy_val = req_ready;
                rdy_ones = $countones(req_ready);
            end
        end
        chk({tag, ".ready_seen"}, 32'(rdy_k != 0), 32'd1);
        chk({tag, ".grant"}, 32'(rdy_val), 32'(1 << g));
        chk({tag, ".onehot"}, 32'(rdy_ones), 32'd1);
        chk({tag, ".latency"}, 32'(rdy_k), 32'(lat));
        chk({tag, ".s_cycles"}, 32'(s_cnt), 32'(exp_s));
        chk({tag, ".r_cycles"}, 32'(r_cnt), 32'(exp_r));
        chk({tag, ".s_and_r"}, 32'(both), 32'd0);
        chk({tag, ".err_cycle"}, 32'(err_k), (stuck && HAS_TO && !skip) ? 32'(lat) : 32'd0);
        if (stuck && HAS_TO && !skip)
            chk({tag, ".err_src"}, 32'(err_src), 32'(g));

        // Acknowledge lasts one cycle; controller is back in IDLE.
        @(negedge clk);
        chk({tag, ".ready_drop"}, 32'(req_ready), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);

        m_ptr = (g + 1) % NREQ;
        if (!skip && !stuck) m_q = op[g];
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.s_out", 32'(s_out), 32'd0);
        chk("rst.r_out", 32'(r_out), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.err_src", 32'(err_src), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single set from requester 0, latch starts at 0
        force_q(1'b0);
        run_op("single_set", 4'b0001, 4'b0001, 0, 1'b0);

        // Reset mid-DRIVE while S is high
        force_q(1'b0);
        req_valid = 4'b0100;
        req_op    = 4'b0100;
        @(negedge clk);
        chk("midrst.s_before", 32'(s_out), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst.s_out", 32'(s_out), 32'd0);
        chk("midrst.r_out", 32'(r_out), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        force_q(1'b0);

        // Round robin with all requesters valid, alternating ops: 0,1,2,3,0
        for (int n = 0; n < 5; n++)
            run_op($sformatf("rr%0d", n), 4'b1111, 4'b1010, 0, 1'b0);

        // Skip: latch already 1, requester 2 asks for set
        force_q(1'b1);
        run_op("skip", 4'b0100, 4'b0100, 0, 1'b0);

        // Drop valid during DRIVE: requester 1 still acknowledged, ptr moves to 2
        force_q(1'b0);
        run_op("drop", 4'b0010, 4'b0010, 1, 1'b0);
        run_op("after_drop", 4'b0111, 4'b0000, 0, 1'b0);

`ifdef SR_CTRL_TIMEOUT_EN
        // Timeout: latch stuck at 0, requester 3 asks for set
        force_q(1'b0);
        lat_stuck = 1'b1;
        run_op("timeout", 4'b1000, 4'b1000, 0, 1'b1);
        lat_stuck = 1'b0;
        chk("timeout.err_src_hold", 32'(err_src), 32'd3);
`else
        chk("noto.err_src", 32'(err_src), 32'd0);
`endif

        // Random operations against the model
        for (int n = 0; n < 30; n++) begin
            logic [NREQ-1:0] v, op;
            v  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            op = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) force_q(1'($urandom));
            run_op($sformatf("rnd%0d", n), v, op, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run ends even if the design wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
